microbot_nav_fsm: RTL and testbench
===================================

Name: microbot_nav_fsm

Overview:
Parametrised next-generation navigation controller for the microbot top level. It debounces the front, left and right obstacle sensors and runs a six-state motion FSM that adds timed back-off, turn timeout and stuck detection. Drives two H-bridge motor channels (A, B) with PWM speed control. It is instantiated under the tt_um_* wrapper, with sensors on ui_in and motors and status on uo_out.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive identical raw samples required before a filtered sensor changes (>=1)
PWM_WIDTH, 8, width of the speed input and of the free-running PWM counter
BACKUP_CYCLES, 16, cycles spent in BACKUP per back-off (>=1)
TURN_TIMEOUT, 64, maximum cycles in RIGHT/LEFT before a forced BACKUP (>=2)
MAX_RETRIES, 3, consecutive BACKUPs without reaching FORWARD that cause STUCK (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  synchronous reset, active-low
en  input  1  run enable; 0 forces STANDBY
f_sensor  input  1  raw front obstacle sensor, 1 = obstacle
l_sensor  input  1  raw left sensor, 1 = obstacle
r_sensor  input  1  raw right sensor, 1 = obstacle
speed  input  PWM_WIDTH  PWM duty threshold
motor_a_fwd  output  1  motor A forward drive
motor_a_rev  output  1  motor A reverse drive
motor_b_fwd  output  1  motor B forward drive
motor_b_rev  output  1  motor B reverse drive
state_o  output  3  current FSM state code
stuck  output  1  1 while in STUCK

Behaviour:
- Clock and reset: single clock clk. rst_n is synchronous and active-low. All registers update on the rising edge of clk.
- Reset values: state STANDBY, all motor outputs 0, stuck 0, state_o 0, PWM counter 0, debounce counters 0, filtered sensors 0, turn/backup timers 0, retry counter 0.
- Debounce, per sensor independently:
  - If raw != filtered, the counter increments; otherwise it clears.
  - When the counter reaches DEBOUNCE_CYCLES-1 while raw still differs, filtered takes raw and the counter clears.
  - Net effect: filtered follows a stable change after DEBOUNCE_CYCLES cycles. Any glitch shorter than that is ignored.
- PWM: pwm_cnt is a PWM_WIDTH-bit counter that increments every cycle and wraps.
  - pwm_on = (pwm_cnt < speed).
  - speed=0 gives drive always off. speed=2^W-1 gives drive off 1 cycle per period.
- State codes: STANDBY=0, FORWARD=1, RIGHT=2, LEFT=3, BACKUP=4, STUCK=5.
- decide(), using filtered fs, ls, rs, first match wins:
  - !fs & (ls==rs) -> FORWARD
  - ls & !rs -> RIGHT
  - !ls & rs -> LEFT
  - fs & !ls & !rs -> RIGHT
  - fs & ls & rs -> BACKUP
- Transitions:
  - en=0 in any state -> STANDBY next cycle, and the retry counter clears. en=0 has priority over everything.
  - STANDBY, en=1 -> decide().
  - FORWARD: holds while !fs & (ls==rs); otherwise -> decide(). Entering FORWARD clears the retry counter.
  - RIGHT: holds while ls & !rs, or fs & !ls & !rs.
  - LEFT: holds while !ls & rs.
  - RIGHT/LEFT timer: counts cycles in state from 0. When the timer reaches TURN_TIMEOUT-1 -> BACKUP, taking priority over hold. If the condition releases first -> decide(). The timer clears on state exit.
  - BACKUP: on entry the retry counter increments.
    - If the retry count after increment equals MAX_RETRIES -> STUCK immediately on the next cycle.
    - Otherwise stays exactly BACKUP_CYCLES cycles, then -> STANDBY.
    - Sensors are ignored in BACKUP.
  - STUCK: holds until en=0.
- Motor direction by state:
  - STANDBY and STUCK: all 0
  - FORWARD: A fwd, B fwd
  - RIGHT: A fwd, B rev
  - LEFT: A rev, B fwd
  - BACKUP: A rev, B rev
- Motor outputs: each output = direction bit & pwm_on, registered. The output at cycle n+1 reflects state and pwm_cnt at cycle n.
- Motor invariant: fwd and rev for a motor are never both 1, including on state changes.
- Status outputs: state_o and stuck are registered copies of state, with 1-cycle latency.
- Reset mid-operation: rst_n=0 in any state (including BACKUP or STUCK) yields the reset values on the next edge. Timers do not resume.

Test Plan:
- Reset, then en=1, speed=255, all sensors 0 -> state_o=1 by cycle 2, motor_a_fwd=motor_b_fwd=1 except 1 cycle per 256, rev outputs 0.
- FORWARD, f_sensor=1 pulse of 3 cycles (DEBOUNCE_CYCLES=4) -> stays FORWARD; pulse held 4+ cycles -> RIGHT (A fwd, B rev).
- l_sensor=0, r_sensor=1 held 100 cycles (TURN_TIMEOUT=64) -> LEFT, then BACKUP after 64 cycles in LEFT, both rev for 16 cycles, then STANDBY.
- All sensors held 1 -> BACKUP, STANDBY, BACKUP, STANDBY, BACKUP, then STUCK, stuck=1, motors 0. Drop en for 1 cycle then raise -> STANDBY, retry cleared.
- speed=0 in FORWARD -> all motor outputs 0 continuously; speed=128 -> exactly 128 of each 256 cycles high.
- rst_n=0 for 1 cycle while in BACKUP at cycle 5 -> next cycle state_o=0, all outputs 0, counters zero.

Source files
------------

// File: rtl/microbot_nav_fsm.sv
// Navigation controller: debounced obstacle sensors feed a six-state motion FSM
// with timed back-off, turn timeout and stuck detection, driving two PWM'd H-bridges.
module microbot_nav_fsm #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PWM_WIDTH       = 8,
  parameter int BACKUP_CYCLES   = 16,
  parameter int TURN_TIMEOUT    = 64,
  parameter int MAX_RETRIES     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic                 f_sensor,
  input  logic                 l_sensor,
  input  logic                 r_sensor,
  input  logic [PWM_WIDTH-1:0] speed,
  output logic                 motor_a_fwd,
  output logic                 motor_a_rev,
  output logic                 motor_b_fwd,
  output logic                 motor_b_rev,
  output logic [2:0]           state_o,
  output logic                 stuck
);

  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int TT_W = $clog2(TURN_TIMEOUT);
  localparam int BK_W = (BACKUP_CYCLES > 1) ? $clog2(BACKUP_CYCLES) : 1;
  localparam int RT_W = $clog2(MAX_RETRIES + 1);

  typedef enum logic [2:0] {
    ST_STANDBY = 3'd0,
    ST_FORWARD = 3'd1,
    ST_RIGHT   = 3'd2,
    ST_LEFT    = 3'd3,
    ST_BACKUP  = 3'd4,
    ST_STUCK   = 3'd5
  } state_t;

  logic [2:0] w_raw;
  logic [2:0] w_filt;

  assign w_raw = {r_sensor, l_sensor, f_sensor};

  // One debounce filter per sensor: bit 0 front, bit 1 left, bit 2 right.
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_db
      logic [DB_W-1:0] r_cnt;
      logic            r_filt;

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_cnt  <= '0;
          r_filt <= 1'b0;
        end else if (w_raw[gi] != r_filt) begin
          if (r_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            r_filt <= w_raw[gi];
            r_cnt  <= '0;
          end else begin
            r_cnt <= r_cnt + DB_W'(1);
          end
        end else begin
          r_cnt <= '0;
        end
      end

      assign w_filt[gi] = r_filt;
    end
  endgenerate

  logic w_fs, w_ls, w_rs;
  assign w_fs = w_filt[0];
  assign w_ls = w_filt[1];
  assign w_rs = w_filt[2];

  state_t          r_state, w_state_next, w_decide;
  logic [TT_W-1:0] r_turn_cnt, w_turn_next;
  logic [BK_W-1:0] r_bk_cnt, w_bk_next;
  logic [RT_W-1:0] r_retry, w_retry_next;
  logic [PWM_WIDTH-1:0] r_pwm_cnt;

  always_comb begin
    w_decide = ST_BACKUP;
    if (!w_fs && (w_ls == w_rs))     w_decide = ST_FORWARD;
    else if (w_ls && !w_rs)          w_decide = ST_RIGHT;
    else if (!w_ls && w_rs)          w_decide = ST_LEFT;
    else if (w_fs && !w_ls && !w_rs) w_decide = ST_RIGHT;
  end

  // The hold condition of FORWARD/RIGHT/LEFT is exactly "decide() picks this state".
  always_comb begin
    w_state_next = r_state;
    w_turn_next  = '0;
    w_bk_next    = '0;
    w_retry_next = r_retry;
    if (!en) begin
      w_state_next = ST_STANDBY;
      w_retry_next = '0;
    end else begin
      case (r_state)
        ST_STANDBY: w_state_next = w_decide;
        ST_FORWARD: w_state_next = w_decide;
        ST_RIGHT, ST_LEFT: begin
          if (r_turn_cnt == TT_W'(TURN_TIMEOUT - 1)) begin
            w_state_next = ST_BACKUP;
          end else if (w_decide == r_state) begin
            w_state_next = r_state;
            w_turn_next  = r_turn_cnt + TT_W'(1);
          end else begin
            w_state_next = w_decide;
          end
        end
        ST_BACKUP: begin
          if (r_retry == RT_W'(MAX_RETRIES)) begin
            w_state_next = ST_STUCK;
          end else if (r_bk_cnt == BK_W'(BACKUP_CYCLES - 1)) begin
            w_state_next = ST_STANDBY;
          end else begin
            w_state_next = ST_BACKUP;
            w_bk_next    = r_bk_cnt + BK_W'(1);
          end
        end
        ST_STUCK:   w_state_next = ST_STUCK;
        default:    w_state_next = ST_STANDBY;
      endcase
      if (w_state_next == ST_BACKUP && r_state != ST_BACKUP) begin
        w_retry_next = r_retry + RT_W'(1);
      end
      if (w_state_next == ST_FORWARD) begin
        w_retry_next = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_STANDBY;
      r_turn_cnt <= '0;
      r_bk_cnt   <= '0;
      r_retry    <= '0;
    end else begin
      r_state    <= w_state_next;
      r_turn_cnt <= w_turn_next;
      r_bk_cnt   <= w_bk_next;
      r_retry    <= w_retry_next;
    end
  end

  // Direction is a pure function of one state, so fwd and rev can never overlap.
  logic [3:0] w_dir;
  logic       w_pwm_on;

  always_comb begin
    w_dir = 4'b0000;
    case (r_state)
      ST_FORWARD: w_dir = 4'b1010;
      ST_RIGHT:   w_dir = 4'b1001;
      ST_LEFT:    w_dir = 4'b0110;
      ST_BACKUP:  w_dir = 4'b0101;
      default:    w_dir = 4'b0000;
    endcase
  end

  assign w_pwm_on = (r_pwm_cnt < speed);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pwm_cnt   <= '0;
      motor_a_fwd <= 1'b0;
      motor_a_rev <= 1'b0;
      motor_b_fwd <= 1'b0;
      motor_b_rev <= 1'b0;
      state_o     <= 3'd0;
      stuck       <= 1'b0;
    end else begin
      r_pwm_cnt   <= r_pwm_cnt + PWM_WIDTH'(1);
      motor_a_fwd <= w_dir[3] & w_pwm_on;
      motor_a_rev <= w_dir[2] & w_pwm_on;
      motor_b_fwd <= w_dir[1] & w_pwm_on;
      motor_b_rev <= w_dir[0] & w_pwm_on;
      state_o     <= r_state;
      stuck       <= (r_state == ST_STUCK);
    end
  end

endmodule

// File: tb/tb_microbot_nav_fsm.sv
// Randomised and directed bench for microbot_nav_fsm against a cycle-level
// behavioural model built from the sensor/motion rules.
module tb_microbot_nav_fsm;

  localparam int DB = 4;
  localparam int PW = 8;
  localparam int BK = 16;
  localparam int TT = 64;
  localparam int MR = 3;

  logic          clk = 1'b0;
  logic          rst_n, en, f_sensor, l_sensor, r_sensor;
  logic [PW-1:0] speed;
  logic          motor_a_fwd, motor_a_rev, motor_b_fwd, motor_b_rev;
  logic [2:0]    state_o;
  logic          stuck;

  always #5 clk = ~clk;

  microbot_nav_fsm #(
    .DEBOUNCE_CYCLES(DB), .PWM_WIDTH(PW), .BACKUP_CYCLES(BK),
    .TURN_TIMEOUT(TT), .MAX_RETRIES(MR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .f_sensor(f_sensor), .l_sensor(l_sensor), .r_sensor(r_sensor),
    .speed(speed),
    .motor_a_fwd(motor_a_fwd), .motor_a_rev(motor_a_rev),
    .motor_b_fwd(motor_b_fwd), .motor_b_rev(motor_b_rev),
    .state_o(state_o), .stuck(stuck)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Model: state codes as integers, time spent in current state, back-off count.
  int          m_state, m_time, m_retry, m_pwm;
  bit          m_filt [3];
  logic [DB-1:0] m_hist [3];
  logic [7:0]  exp_vec;
  wire  [7:0]  dut_vec = {motor_a_fwd, motor_a_rev, motor_b_fwd, motor_b_rev, state_o, stuck};

  function automatic int decide(bit fs, bit ls, bit rs);
    if (!fs && ls == rs) return 1;
    if (ls && !rs) return 2;
    if (!ls && rs) return 3;
    if (fs && !ls && !rs) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] drive_of(int s);
    case (s)
      1: return 4'b1010;
      2: return 4'b1001;
      3: return 4'b0110;
      4: return 4'b0101;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_step();
    int nxt;
    bit raw [3];
    raw[0] = f_sensor; raw[1] = l_sensor; raw[2] = r_sensor;
    if (!rst_n) begin
      m_state = 0; m_time = 0; m_retry = 0; m_pwm = 0;
      for (int i = 0; i < 3; i++) begin m_filt[i] = 0; m_hist[i] = '0; end
      exp_vec = 8'h00;
      return;
    end
    exp_vec = {drive_of(m_state) & {4{m_pwm < int'(speed)}}, 3'(m_state), (m_state == 5)};
    if (!en) begin
      nxt = 0;
      m_retry = 0;
    end else begin
      case (m_state)
        0, 1: nxt = decide(m_filt[0], m_filt[1], m_filt[2]);
        2, 3: nxt = (m_time == TT - 1) ? 4 : decide(m_filt[0], m_filt[1], m_filt[2]);
        4:    nxt = (m_retry == MR) ? 5 : ((m_time == BK - 1) ? 0 : 4);
        default: nxt = 5;
      endcase
      if (nxt == 4 && m_state != 4) m_retry++;
      if (nxt == 1) m_retry = 0;
    end
    if (nxt != m_state) m_time = 0; else m_time++;
    m_state = nxt;
    // A sensor flips once its last DB raw samples all disagree with it.
    for (int i = 0; i < 3; i++) begin
      m_hist[i] = {m_hist[i][DB-2:0], raw[i]};
      if (m_hist[i] == {DB{~m_filt[i]}}) m_filt[i] = raw[i];
    end
    m_pwm = (m_pwm + 1) % (1 << PW);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_sens(bit f, bit l, bit r);
    f_sensor = f; l_sensor = l; r_sensor = r;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b0; speed = '0; set_sens(0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL reset_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
    end
    total++;
    if (dut_vec !== 8'h00) begin
      bad++; $display("FAIL reset_zero got=%b want=00000000", dut_vec);
    end
    $display("test_reset done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_forward();
    int a_on = 0, b_on = 0, rev_on = 0;
    rst_n = 1'b1; en = 1'b1; speed = 8'd255;
    tick(); tick();
    total++;
    if (state_o !== 3'd1) begin
      bad++; $display("FAIL fwd_entry state_o=%0d want=1", state_o);
    end
    for (int i = 0; i < 256; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL fwd_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
      a_on += motor_a_fwd; b_on += motor_b_fwd; rev_on += motor_a_rev + motor_b_rev;
    end
    total++;
    if (a_on != 255 || b_on != 255 || rev_on != 0) begin
      bad++; $display("FAIL fwd_duty a=%0d b=%0d rev=%0d want 255/255/0", a_on, b_on, rev_on);
    end
    $display("test_forward done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_glitch();
    f_sensor = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (i == 3) f_sensor = 1'b0;
      tick();
      total++;
      if (dut_vec !== exp_vec || state_o !== 3'd1) begin
        bad++; $display("FAIL glitch_hold cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
    end
    f_sensor = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL glitch_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
    end
    total++;
    if (state_o !== 3'd2 || motor_a_rev !== 1'b0 || motor_b_fwd !== 1'b0) begin
      bad++; $display("FAIL front_turn state_o=%0d a_rev=%b b_fwd=%b want 2/0/0", state_o, motor_a_rev, motor_b_fwd);
    end
    $display("test_glitch done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_turn_timeout();
    int trace [100];
    int idx = 0, n_left = 0, n_back = 0, after = -1;
    set_sens(0, 0, 1);
    for (int i = 0; i < 100; i++) begin
      tick();
      trace[i] = int'(state_o);
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL turn_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
    end
    while (idx < 100 && trace[idx] != 3) idx++;
    while (idx < 100 && trace[idx] == 3) begin n_left++; idx++; end
    while (idx < 100 && trace[idx] == 4) begin n_back++; idx++; end
    if (idx < 100) after = trace[idx];
    total++;
    if (n_left != TT || n_back != BK || after != 0) begin
      bad++; $display("FAIL turn_timeout left=%0d backup=%0d next=%0d want %0d/%0d/0", n_left, n_back, after, TT, BK);
    end
    $display("test_turn_timeout done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_stuck();
    int entries = 0, prev = 0, run = 0;
    bit counting = 1;
    en = 1'b0; set_sens(1, 1, 1);
    for (int i = 0; i < 6; i++) tick();
    en = 1'b1;
    for (int i = 0; i < 80; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL stuck_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
      if (state_o == 3'd4 && prev != 4) entries++;
      prev = int'(state_o);
    end
    total++;
    if (entries != MR || stuck !== 1'b1 || state_o !== 3'd5 ||
        {motor_a_fwd, motor_a_rev, motor_b_fwd, motor_b_rev} !== 4'b0000) begin
      bad++; $display("FAIL stuck_entry backups=%0d stuck=%b state_o=%0d want %0d/1/5", entries, stuck, state_o, MR);
    end
    en = 1'b0; tick();
    en = 1'b1; tick();
    total++;
    if (state_o !== 3'd0) begin
      bad++; $display("FAIL stuck_release state_o=%0d want=0", state_o);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL release_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
      if (counting && state_o == 3'd4) run++; else counting = 0;
    end
    total++;
    if (run != BK) begin
      bad++; $display("FAIL retry_cleared backup_run=%0d want=%0d", run, BK);
    end
    $display("test_stuck done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_speed();
    int on_a = 0, on_b = 0, any_on = 0;
    en = 1'b0; set_sens(0, 0, 0);
    for (int i = 0; i < 6; i++) tick();
    en = 1'b1; speed = 8'd0;
    for (int i = 0; i < 3; i++) tick();
    for (int i = 0; i < 300; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL speed0_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
      any_on += motor_a_fwd + motor_a_rev + motor_b_fwd + motor_b_rev;
    end
    total++;
    if (any_on != 0) begin
      bad++; $display("FAIL speed0_off high_count=%0d want=0", any_on);
    end
    speed = 8'd128;
    for (int i = 0; i < 256; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL speed128_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
      on_a += motor_a_fwd; on_b += motor_b_fwd;
    end
    total++;
    if (on_a != 128 || on_b != 128) begin
      bad++; $display("FAIL speed128_duty a=%0d b=%0d want=128", on_a, on_b);
    end
    $display("test_speed done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_reset_mid();
    int waited = 0;
    set_sens(1, 1, 1);
    while (state_o !== 3'd4 && waited < 40) begin
      tick();
      waited++;
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL rstmid_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
    end
    total++;
    if (state_o !== 3'd4) begin
      bad++; $display("FAIL backup_timeout state_o=%0d want=4 within 40 cycles", state_o);
    end
    for (int i = 0; i < 4; i++) tick();
    rst_n = 1'b0;
    tick();
    total++;
    if (dut_vec !== 8'h00) begin
      bad++; $display("FAIL rst_in_backup got=%b want=00000000", dut_vec);
    end
    rst_n = 1'b1; set_sens(0, 0, 0);
    for (int i = 0; i < 30; i++) begin
      tick();
      total++;
      if (dut_vec !== exp_vec) begin
        bad++; $display("FAIL post_rst_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
      end
    end
    $display("test_reset_mid done total=%0d bad=%0d", total, bad);
  endtask

  task automatic test_random();
    int n = 0;
    while (n < 3000) begin
      int hold;
      hold = $urandom_range(12, 1);
      set_sens($urandom_range(1, 0), $urandom_range(1, 0), $urandom_range(1, 0));
      if ($urandom_range(7, 0) == 0) set_sens(1, 1, 1);
      en    = ($urandom_range(29, 0) != 0);
      rst_n = ($urandom_range(59, 0) != 0);
      if ($urandom_range(9, 0) == 0) speed = PW'($urandom_range(255, 0));
      for (int i = 0; i < hold; i++) begin
        tick();
        n++;
        total++;
        if (dut_vec !== exp_vec) begin
          bad++; $display("FAIL random_model cyc=%0d got=%b want=%b", cyc, dut_vec, exp_vec);
        end
        rst_n = 1'b1;
      end
    end
    $display("test_random done total=%0d bad=%0d", total, bad);
  endtask

  initial begin
    test_reset();
    test_forward();
    test_glitch();
    test_turn_timeout();
    test_stuck();
    test_speed();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
